// File: rtl/axi_basic_rx_pkt_pad.sv
// RX length-enforcing stage: decodes TLP header length, pads short/discontinued TLPs
// with zero beats and truncates overlong TLPs, all with zero-cycle pass-through latency.
module axi_basic_rx_pkt_pad #(
  parameter int C_DATA_WIDTH  = 128,
  parameter int C_TUSER_WIDTH = 22,
  parameter int TCQ           = 1,
  parameter int KEEP_WIDTH    = C_DATA_WIDTH/8
) (
  input  logic                     user_clk,
  input  logic                     user_rst_n,
  input  logic [C_DATA_WIDTH-1:0]  s_axis_rx_tdata,
  input  logic                     s_axis_rx_tvalid,
  output logic                     s_axis_rx_tready,
  input  logic                     s_axis_rx_tlast,
  input  logic [KEEP_WIDTH-1:0]    s_axis_rx_tkeep,
  input  logic [C_TUSER_WIDTH-1:0] s_axis_rx_tuser,
  input  logic                     s_axis_rx_dsc,
  output logic [C_DATA_WIDTH-1:0]  m_axis_rx_tdata,
  output logic                     m_axis_rx_tvalid,
  input  logic                     m_axis_rx_tready,
  output logic                     m_axis_rx_tlast,
  output logic [KEEP_WIDTH-1:0]    m_axis_rx_tkeep,
  output logic [C_TUSER_WIDTH-1:0] m_axis_rx_tuser,
  output logic                     err_short,
  output logic                     err_long,
  output logic [15:0]              pad_cnt
);

  localparam int unsigned NDW = C_DATA_WIDTH/32;
  localparam logic [11:0] N   = 12'(NDW);

  // TCQ is kept for parameter compatibility only; registers carry no modelled delay.
  if (TCQ < 0) begin : g_tcq_range
  end

  typedef enum logic [1:0] {IDLE, IN_PKT, PAD, DROP} state_e;

  state_e      state_q, state_d;
  logic [11:0] rem_q, rem_d;
  logic        err_short_q, err_short_d;
  logic        err_long_q, err_long_d;
  logic [15:0] pad_cnt_q, pad_cnt_d;

  logic [1:0]            fmt;
  logic                  td;
  logic [9:0]            len;
  logic [10:0]           len_dw;
  logic [11:0]           total;
  logic [11:0]           rem_now;
  logic                  final_beat;
  logic [KEEP_WIDTH-1:0] fin_keep;

  always_comb begin
    fmt        = s_axis_rx_tdata[30:29];
    td         = s_axis_rx_tdata[15];
    len        = s_axis_rx_tdata[9:0];
    len_dw     = (len == '0) ? 11'd1024 : {1'b0, len};
    total      = (fmt[0] ? 12'd4 : 12'd3) + {11'd0, td} + (fmt[1] ? {1'b0, len_dw} : 12'd0);
    rem_now    = (state_q == IDLE) ? total : rem_q;
    final_beat = (rem_now <= N);
    fin_keep   = '0;
    for (int unsigned j = 0; j < NDW; j++) begin
      fin_keep[4*j +: 4] = (rem_now > 12'(j)) ? 4'hF : 4'h0;
    end
  end

  always_comb begin
    state_d          = state_q;
    rem_d            = rem_q;
    err_short_d      = 1'b0;
    err_long_d       = 1'b0;
    pad_cnt_d        = pad_cnt_q;
    s_axis_rx_tready = 1'b0;
    m_axis_rx_tvalid = 1'b0;
    m_axis_rx_tdata  = '0;
    m_axis_rx_tuser  = '0;
    m_axis_rx_tkeep  = '0;
    m_axis_rx_tlast  = 1'b0;

    unique case (state_q)
      IDLE, IN_PKT: begin
        m_axis_rx_tvalid = s_axis_rx_tvalid;
        s_axis_rx_tready = m_axis_rx_tready;
        m_axis_rx_tdata  = s_axis_rx_tdata;
        m_axis_rx_tuser  = s_axis_rx_tuser;
        m_axis_rx_tkeep  = final_beat ? fin_keep : s_axis_rx_tkeep;
        // A final beat always ends the TLP; a non-final one never may, so tlast reduces to final_beat.
        m_axis_rx_tlast  = final_beat;
        if (s_axis_rx_tvalid && m_axis_rx_tready) begin
          if (final_beat) begin
            rem_d = '0;
            if (s_axis_rx_tlast) begin
              state_d = IDLE;
            end else begin
              err_long_d = 1'b1;
              state_d    = DROP;
            end
          end else begin
            rem_d = rem_now - N;
            if (s_axis_rx_dsc || s_axis_rx_tlast) begin
              err_short_d = 1'b1;
              pad_cnt_d   = (pad_cnt_q == 16'hFFFF) ? pad_cnt_q : pad_cnt_q + 16'd1;
              state_d     = PAD;
            end else begin
              state_d = IN_PKT;
            end
          end
        end
      end
      PAD: begin
        m_axis_rx_tvalid = 1'b1;
        m_axis_rx_tkeep  = fin_keep;
        m_axis_rx_tlast  = (rem_q <= N);
        if (m_axis_rx_tready) begin
          if (rem_q <= N) begin
            rem_d   = '0;
            state_d = IDLE;
          end else begin
            rem_d = rem_q - N;
          end
        end
      end
      DROP: begin
        s_axis_rx_tready = 1'b1;
        if (s_axis_rx_tvalid && s_axis_rx_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      pad_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      pad_cnt_q   <= pad_cnt_d;
    end
  end

  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign pad_cnt   = pad_cnt_q;

endmodule
